// File: rtl/j1_io_pkg.sv
// j1_io_pkg
// Shared constants for the j1 I/O byte-stream hub:
//   - address bits that pick the data port, the status port and the channel field
//   - bit positions inside the status word
//   - a helper that packs one channel's status word
package j1_io_pkg;

    localparam int IO_UART_BIT   = 12;
    localparam int IO_STATUS_BIT = 13;
    localparam int IO_CH_LSB     = 4;

    localparam int ST_TXNF    = 0;
    localparam int ST_RXNE    = 1;
    localparam int ST_RXDROP  = 2;
    localparam int ST_TXOVF   = 3;
    localparam int ST_CNT_LSB = 8;

    typedef logic [7:0] byte_t;

    // Count arrives as 9 bits so a 256-deep FIFO can report "full";
    // the status field only holds 8 bits, so 256 reads back as 255.
    function automatic logic [15:0] status_word(
        input logic [8:0] cnt,
        input logic       txovf,
        input logic       rxdrop,
        input logic       rxne,
        input logic       txnf
    );
        logic [15:0] w;
        w                    = '0;
        w[ST_CNT_LSB +: 8]   = cnt[8] ? 8'hFF : cnt[7:0];
        w[ST_TXOVF]          = txovf;
        w[ST_RXDROP]         = rxdrop;
        w[ST_RXNE]           = rxne;
        w[ST_TXNF]           = txnf;
        return w;
    endfunction

endpackage

// File: rtl/j1_byte_fifo.sv
// j1_byte_fifo
// 8-bit synchronous FIFO, DEPTH entries (power of two).
// Ports:
//   clk, resetq     clock, asynchronous active-low reset
//   i_push, i_data  push request and byte; ignored while full
//   i_pop           pop request; ignored while empty
//   o_head          byte at the read pointer (meaningful when not empty)
//   o_count         occupancy, one bit wider than the pointers
//   o_full, o_empty occupancy flags
// Full/empty come from the registered count, so a push into a full FIFO is
// refused even if a pop happens in the same cycle.
module j1_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetq,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/j1_uart_hub.sv
// j1_uart_hub
// Byte-stream I/O hub between the j1 core I/O port and CHANNELS host-side
// byte streams. Each channel owns an RX FIFO (host -> core) and a TX FIFO
// (core -> host).
// Ports:
//   clk, resetq            clock, asynchronous active-low reset
//   io_rd, io_wr           core I/O strobes
//   mem_addr, dout         core I/O address and write data
//   io_din                 read data to the core (valid the cycle after io_rd)
//   tx_valid/tx_data/tx_ready   per-channel TX stream to the host
//   rx_valid/rx_data/rx_ready   per-channel RX stream from the host
// Address map (after the one-cycle capture):
//   bit 12  data port   : write pushes TX, read pops RX
//   bit 13  status port : read status word, write clears sticky flags
//   [4+:CHW] channel; channels >= CHANNELS read 0 and ignore writes
module j1_uart_hub
    import j1_io_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    resetq,
    input  logic                    io_rd,
    input  logic                    io_wr,
    input  logic [15:0]             mem_addr,
    input  logic [15:0]             dout,
    output logic [15:0]             io_din,
    output logic [CHANNELS-1:0]     tx_valid,
    output logic [8*CHANNELS-1:0]   tx_data,
    input  logic [CHANNELS-1:0]     tx_ready,
    input  logic [CHANNELS-1:0]     rx_valid,
    input  logic [8*CHANNELS-1:0]   rx_data,
    output logic [CHANNELS-1:0]     rx_ready
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam int TCW = $clog2(TX_DEPTH) + 1;

    logic          r_io_rd;
    logic          r_io_wr;
    logic [15:0]   r_dout;
    logic [15:0]   r_io_addr;
    logic [CHANNELS-1:0] r_tx_ovf;
    logic [CHANNELS-1:0] r_rx_drop;

    logic [CHW-1:0] w_ch;
    logic           w_data_sel;
    logic           w_stat_sel;

    logic [CHANNELS-1:0] w_sel;
    logic [CHANNELS-1:0] w_tx_push;
    logic [CHANNELS-1:0] w_tx_pop;
    logic [CHANNELS-1:0] w_tx_full;
    logic [CHANNELS-1:0] w_tx_empty;
    logic [CHANNELS-1:0] w_rx_push;
    logic [CHANNELS-1:0] w_rx_pop;
    logic [CHANNELS-1:0] w_rx_full;
    logic [CHANNELS-1:0] w_rx_empty;
    logic [CHANNELS-1:0] w_ovf_set;
    logic [CHANNELS-1:0] w_ovf_clr;
    logic [CHANNELS-1:0] w_drop_set;
    logic [CHANNELS-1:0] w_drop_clr;

    byte_t       w_rx_head  [CHANNELS];
    byte_t       w_tx_head  [CHANNELS];
    logic [8:0]  w_rx_cnt9  [CHANNELS];

    logic [15:0] w_rd_word;
    logic        w_unused;

    // Core-side capture: the address is held between accesses so io_din
    // stays tied to the last addressed port.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_io_rd   <= 1'b0;
            r_io_wr   <= 1'b0;
            r_dout    <= '0;
            r_io_addr <= '0;
        end else begin
            r_io_rd <= io_rd;
            r_io_wr <= io_wr;
            r_dout  <= dout;
            if (io_rd | io_wr)
                r_io_addr <= mem_addr;
        end
    end

    assign w_ch       = r_io_addr[IO_CH_LSB +: CHW];
    assign w_data_sel = r_io_addr[IO_UART_BIT];
    assign w_stat_sel = r_io_addr[IO_STATUS_BIT];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [RCW-1:0] w_rx_count;
        logic [TCW-1:0] w_tx_count_unused;

        // An out-of-range channel matches no w_sel bit, so it reads 0 and
        // its writes fall on the floor.
        assign w_sel[c]      = (w_ch == CHW'(c));

        assign w_tx_push[c]  = r_io_wr & w_data_sel & w_sel[c];
        assign w_tx_pop[c]   = tx_ready[c] & ~w_tx_empty[c];
        assign w_rx_push[c]  = rx_valid[c] & ~w_rx_full[c];
        assign w_rx_pop[c]   = r_io_rd & w_data_sel & w_sel[c] & ~w_rx_empty[c];

        assign w_ovf_set[c]  = w_tx_push[c] & w_tx_full[c];
        assign w_drop_set[c] = rx_valid[c] & w_rx_full[c];
        assign w_ovf_clr[c]  = r_io_wr & w_stat_sel & w_sel[c] & r_dout[ST_TXOVF];
        assign w_drop_clr[c] = r_io_wr & w_stat_sel & w_sel[c] & r_dout[ST_RXDROP];

        assign tx_valid[c]        = ~w_tx_empty[c];
        assign tx_data[8*c +: 8]  = w_tx_head[c];
        assign rx_ready[c]        = ~w_rx_full[c];
        assign w_rx_cnt9[c]       = 9'(w_rx_count);

        j1_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
            .clk     (clk),
            .resetq  (resetq),
            .i_push  (w_rx_push[c]),
            .i_data  (rx_data[8*c +: 8]),
            .i_pop   (w_rx_pop[c]),
            .o_head  (w_rx_head[c]),
            .o_count (w_rx_count),
            .o_full  (w_rx_full[c]),
            .o_empty (w_rx_empty[c])
        );

        j1_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
            .clk     (clk),
            .resetq  (resetq),
            .i_push  (w_tx_push[c]),
            .i_data  (r_dout[7:0]),
            .i_pop   (w_tx_pop[c]),
            .o_head  (w_tx_head[c]),
            .o_count (w_tx_count_unused),
            .o_full  (w_tx_full[c]),
            .o_empty (w_tx_empty[c])
        );
    end

    // A new error event in the same cycle as a clear wins, so it is never lost.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_tx_ovf  <= '0;
            r_rx_drop <= '0;
        end else begin
            r_tx_ovf  <= (r_tx_ovf  & ~w_ovf_clr)  | w_ovf_set;
            r_rx_drop <= (r_rx_drop & ~w_drop_clr) | w_drop_set;
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_sel[c]) begin
                if (w_data_sel && !w_rx_empty[c])
                    w_rd_word = w_rd_word | {8'h00, w_rx_head[c]};
                if (w_stat_sel)
                    w_rd_word = w_rd_word | status_word(w_rx_cnt9[c], r_tx_ovf[c],
                                                        r_rx_drop[c], ~w_rx_empty[c],
                                                        ~w_tx_full[c]);
            end
        end
    end

    assign io_din = w_rd_word;

    // Address and data bits outside the decoded fields are intentionally unused.
    assign w_unused = &{1'b0, r_io_addr, r_dout};

endmodule

// File: tb/tb_j1_uart_hub.sv
module tb_j1_uart_hub;

    localparam int CH  = 3;
    localparam int RXD = 4;
    localparam int TXD = 4;

    logic              clk = 1'b0;
    logic              resetq;
    logic              io_rd;
    logic              io_wr;
    logic [15:0]       mem_addr;
    logic [15:0]       dout;
    logic [15:0]       io_din;
    logic [CH-1:0]     tx_valid;
    logic [8*CH-1:0]   tx_data;
    logic [CH-1:0]     tx_ready;
    logic [CH-1:0]     rx_valid;
    logic [8*CH-1:0]   rx_data;
    logic [CH-1:0]     rx_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    j1_uart_hub #(.CHANNELS(CH), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk      (clk),
        .resetq   (resetq),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .mem_addr (mem_addr),
        .dout     (dout),
        .io_din   (io_din),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] a_data(input int c);
        return 16'h1000 | 16'(c << 4);
    endfunction

    function automatic logic [15:0] a_stat(input int c);
        return 16'h2000 | 16'(c << 4);
    endfunction

    // Returns in the io_rd_ cycle with io_din sampled; the pop commits at the next edge.
    task automatic core_rd(input logic [15:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        io_rd = 1'b1; mem_addr = a;
        @(posedge clk); #1;
        io_rd = 1'b0;
        d = io_din;
    endtask

    task automatic core_wr(input logic [15:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        io_wr = 1'b1; mem_addr = a; dout = v;
        @(posedge clk); #1;
        io_wr = 1'b0;
    endtask

    task automatic host_push(input int c, input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid[c] = 1'b1; rx_data[8*c +: 8] = b;
        @(posedge clk); #1;
        rx_valid[c] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [15:0] d;
        int          n;

        resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b0; mem_addr = '0; dout = '0;
        tx_ready = '0; rx_valid = '0; rx_data = '0;
        #12;
        chk("rst_io_din",   io_din,   16'h0000);
        chk("rst_tx_valid", tx_valid, 3'b000);
        chk("rst_rx_ready", rx_ready, 3'b111);
        resetq = 1'b1;
        idle(2);

        core_rd(a_stat(0), d);
        chk("stat0_after_rst", d, 16'h0001);
        chk("rx_ready_idle", rx_ready, 3'b111);
        chk("tx_valid_idle", tx_valid, 3'b000);

        // Host RX on ch1 then drain it from the core side.
        host_push(1, 8'h41);
        host_push(1, 8'h42);
        core_rd(a_stat(1), d);
        chk("stat1_two", d, 16'h0203);
        core_rd(a_data(1), d);
        chk("rd1_first", d, 16'h0041);
        core_rd(a_data(1), d);
        chk("rd1_second", d, 16'h0042);
        core_rd(a_data(1), d);
        chk("rd1_empty", d, 16'h0000);

        // TX overflow on ch0 with the host stalled.
        for (int i = 0; i < TXD + 1; i++)
            core_wr(a_data(0), 16'h0055);
        core_rd(a_stat(0), d);
        chk("stat0_tx_ovf", d, 16'h0008);
        chk("tx_valid0_full", tx_valid, 3'b001);
        core_wr(a_stat(0), 16'h0008);
        core_rd(a_stat(0), d);
        chk("stat0_ovf_clr", d, 16'h0000);

        tx_ready[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid[0]) begin
                n++;
                chk("tx0_byte", {24'h0, tx_data[7:0]}, 32'h55);
            end
            @(posedge clk); #1;
        end
        chk("tx0_byte_count", n, TXD);
        chk("tx_valid_drained", tx_valid, 3'b000);
        tx_ready[0] = 1'b0;

        // RX full, back-pressure and drop flag on ch0.
        for (int i = 0; i < RXD; i++)
            host_push(0, 8'h10 + 8'(i));
        chk("rx_ready0_full", rx_ready, 3'b110);
        host_push(0, 8'h14);
        core_rd(a_stat(0), d);
        chk("stat0_rx_full_drop", d, 16'h0407);
        core_rd(a_data(0), d);
        chk("rd0_oldest", d, 16'h0010);
        @(posedge clk); #1;
        chk("rx_ready0_after_pop", rx_ready, 3'b111);
        core_wr(a_stat(0), 16'h0004);
        core_rd(a_stat(0), d);
        chk("stat0_drop_clr", d, 16'h0303);

        // Channel 3 does not exist with three channels.
        core_wr(a_data(3), 16'h0077);
        core_rd(a_stat(3), d);
        chk("stat3_absent", d, 16'h0000);
        chk("tx_valid_ch3_ignored", tx_valid, 3'b000);
        core_rd(a_data(3), d);
        chk("rd3_absent", d, 16'h0000);

        // Same-cycle host push and core pop at count 1 (ch2).
        host_push(2, 8'hA1);
        @(posedge clk); #1;
        io_rd = 1'b1; mem_addr = a_data(2);
        @(posedge clk); #1;
        io_rd = 1'b0; rx_valid[2] = 1'b1; rx_data[23:16] = 8'hA2;
        d = io_din;
        @(posedge clk); #1;
        rx_valid[2] = 1'b0;
        chk("push_pop_old_byte", d, 16'h00A1);
        core_rd(a_stat(2), d);
        chk("push_pop_count", d, 16'h0103);
        core_rd(a_data(2), d);
        chk("push_pop_new_byte", d, 16'h00A2);

        // Same-cycle host push into an empty FIFO and core read (ch1).
        @(posedge clk); #1;
        io_rd = 1'b1; mem_addr = a_data(1);
        @(posedge clk); #1;
        io_rd = 1'b0; rx_valid[1] = 1'b1; rx_data[15:8] = 8'hB2;
        d = io_din;
        @(posedge clk); #1;
        rx_valid[1] = 1'b0;
        chk("empty_push_rd_zero", d, 16'h0000);
        core_rd(a_stat(1), d);
        chk("empty_push_count", d, 16'h0103);
        core_rd(a_data(1), d);
        chk("empty_push_byte", d, 16'h00B2);

        // Reset mid-stream.
        host_push(1, 8'hC1);
        core_wr(a_data(0), 16'h0066);
        core_rd(a_stat(1), d);
        chk("pre_rst_stat1", d, 16'h0103);
        chk("pre_rst_tx_valid", tx_valid, 3'b001);
        resetq = 1'b0;
        #1;
        chk("midrst_io_din",   io_din,   16'h0000);
        chk("midrst_tx_valid", tx_valid, 3'b000);
        chk("midrst_rx_ready", rx_ready, 3'b111);
        #7;
        resetq = 1'b1;
        core_rd(a_data(1), d);
        chk("post_rst_rd1", d, 16'h0000);
        core_rd(a_stat(0), d);
        chk("post_rst_stat0", d, 16'h0001);
        core_rd(a_data(0), d);
        chk("post_rst_rd0", d, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/j1_uart_hub.md
# j1_uart_hub

Parametrised byte-stream I/O block between the j1 core's I/O port (io_rd/io_wr, mem_addr, dout, io_din) and CHANNELS host-side UART byte streams.
- Each channel has an RX FIFO and a TX FIFO with valid/ready handshakes on the host side.
- The status word reports real FIFO state plus sticky error flags, replacing the constant "TX ready" status of the single-channel design.
- Sits in the j1a top level in place of the inline UART decode; core-visible latency is unchanged.

## Interface
Parameters:
- CHANNELS, 2: number of UART channels, 1..4.
- RX_DEPTH, 16: RX FIFO entries per channel, power of two, 2..256.
- TX_DEPTH, 16: TX FIFO entries per channel, power of two, 2..256.

Ports:
- clk  in  1  single clock.
- resetq  in  1  reset: asynchronous, active-low.
- io_rd  in  1  core I/O read strobe.
- io_wr  in  1  core I/O write strobe.
- mem_addr  in  16  core I/O address.
- dout  in  16  core write data.
- io_din  out  16  read data to the core.
- tx_valid  out  CHANNELS  per channel: TX FIFO non-empty.
- tx_data  out  8*CHANNELS  per channel: TX FIFO head byte (channel c at [8c+7:8c]).
- tx_ready  in  CHANNELS  per channel: host accepts the head byte this cycle.
- rx_valid  in  CHANNELS  per channel: host offers a byte.
- rx_data  in  8*CHANNELS  per channel: offered byte.
- rx_ready  out  CHANNELS  per channel: RX FIFO not full.

## Operation
- **Decode.** On any cycle with io_rd|io_wr, capture mem_addr into io_addr_. Capture io_rd, io_wr and dout every cycle into io_rd_, io_wr_ and dout_.
- **Channel select.** ch = io_addr_[4+:CHW], where CHW = max(1, clog2(CHANNELS)). If ch >= CHANNELS: reads return 0 and writes are ignored.
- **Data port (io_addr_[12]).**
  - Write (io_wr_): push dout_[7:0] into TX FIFO ch. If that FIFO is full, drop the byte and set sticky tx_ovf[ch].
  - Read (io_rd_): io_din = {8'h00, RX head} and pop. If the RX FIFO is empty, io_din = 0 and there is no pop.
- **Status port (io_addr_[13]).**
  - Read word: [15:8] RX count of ch, saturated at 255; [7:4] 0; [3] tx_ovf; [2] rx_drop; [1] RX non-empty; [0] TX not full.
  - Write: dout_[3]=1 clears tx_ovf[ch]; dout_[2]=1 clears rx_drop[ch].
- **Both bits 12 and 13 set.** io_din is the OR of both read words. A read pops the RX FIFO; a write pushes to the TX FIFO and applies the clear bits.
- **io_din outside an access.** io_din is combinational from io_addr_ and the FIFO state. It is meaningful only in the cycle io_rd_ is high.
- **Host RX.** A byte is pushed when rx_valid & rx_ready. rx_drop[ch] sets when rx_valid is high while rx_ready is low; it records host back-pressure for diagnostics only.
- **Host TX.** A byte is popped when tx_valid & tx_ready.
- **Simultaneous push and pop on one FIFO.** Both occur and the count is unchanged.
  - rx_ready/TX-full are decided from the count at the start of the cycle.
  - So a full FIFO does not accept a push in a cycle where it also pops.
  - An empty FIFO returns 0 to a same-cycle core read; the host byte lands afterwards.
- **Wrap-around.** Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits, so the full and empty states are distinct.

## Timing
- io_rd in cycle N: io_din valid in cycle N+1; the RX pop commits at the clock edge ending N+1.
- io_wr in cycle N: the TX push commits at the edge ending N+1. tx_valid can rise in N+2 at the earliest.
- Host RX push in cycle M is visible to a core read whose io_rd_ cycle is M+1 or later.
- Back-to-back reads (io_rd in N and N+1) pop two distinct bytes.
- Reset values (asynchronous on resetq low):
  - All FIFOs empty; io_rd_, io_wr_, dout_, io_addr_ all 0.
  - io_din = 0; tx_valid = 0; rx_ready = all ones; tx_ovf = 0; rx_drop = 0.
- Reset mid-operation discards FIFO contents. Reset release needs no sequencing.

## Structure
- Package j1_io_pkg:
  - IO_UART_BIT = 12, IO_STATUS_BIT = 13, IO_CH_LSB = 4.
  - Status bit positions: ST_TXNF = 0, ST_RXNE = 1, ST_RXDROP = 2, ST_TXOVF = 3, ST_CNT_LSB = 8.
- Sub-module j1_byte_fifo (parameter DEPTH): 8-bit synchronous FIFO with push/pop, head data, count, full and empty. The hub instantiates 2*CHANNELS copies from a generate loop.

## Test plan
- Reset, then status read on ch0 -> io_din = 16'h0001; rx_ready = all ones; tx_valid = 0.
- Host pushes 0x41, 0x42 on ch1; status read ch1 -> 16'h0203; data reads -> 0x0041 then 0x0042; a third read -> 0x0000.
- Core writes 0x55 to ch0 with tx_ready held low, TX_DEPTH+1 times:
  - status -> 16'h0008 (TX full, tx_ovf set);
  - write status with dout = 16'h0008 -> bit 3 clears;
  - raise tx_ready -> exactly TX_DEPTH bytes of 0x55 emerge.
- Host fills ch0 RX to RX_DEPTH -> rx_ready[0] = 0. Host holds rx_valid -> rx_drop sets. One core read -> rx_ready[0] = 1 the next cycle.
- Same-cycle host push and core pop at count 1 -> count stays 1 and the popped byte is the older one.
- Assert resetq low mid-stream with FIFOs holding data -> all outputs return to reset values immediately; subsequent reads return 0.
